// File: rtl/rob_issue_cdb.sv
// Reorder buffer with integrated issue window: CDB wakeup, oldest-first dispatch, in-order commit.
// Optional `define ROB_FLUSH_EN adds a synchronous flush input that empties the buffer.
module rob_issue_cdb #(
    parameter int DATA_WIDTH = 32,
    parameter int ROB_SIZE   = 16,
    parameter int TAG_WIDTH  = $clog2(ROB_SIZE),
    parameter int EXEC_WIDTH = 4,
    parameter int CDB_PORTS  = 2
) (
    input  logic                            clk,
    input  logic                            rst,
`ifdef ROB_FLUSH_EN
    input  logic                            flush,
`endif
    input  logic                            halt,
    input  logic                            alloc_valid,
    output logic                            alloc_ready,
    input  logic                            alloc_rtype,
    input  logic [EXEC_WIDTH-1:0]           alloc_exec_id,
    input  logic [DATA_WIDTH-1:0]           alloc_imm,
    input  logic [4:0]                      alloc_rd,
    output logic [TAG_WIDTH-1:0]            alloc_tag,
    input  logic                            rs1_valid,
    input  logic                            rs2_valid,
    input  logic [TAG_WIDTH-1:0]            rs1_tag,
    input  logic [TAG_WIDTH-1:0]            rs2_tag,
    input  logic [DATA_WIDTH-1:0]           rs1_data,
    input  logic [DATA_WIDTH-1:0]           rs2_data,
    input  logic [2**EXEC_WIDTH-1:0]        fu_available,
    output logic                            disp_valid,
    output logic [DATA_WIDTH-1:0]           disp_op1,
    output logic [DATA_WIDTH-1:0]           disp_op2,
    output logic [EXEC_WIDTH-1:0]           disp_exec_id,
    output logic [TAG_WIDTH-1:0]            disp_tag,
    input  logic [CDB_PORTS-1:0]            cdb_valid,
    input  logic [CDB_PORTS*TAG_WIDTH-1:0]  cdb_tag,
    input  logic [CDB_PORTS*DATA_WIDTH-1:0] cdb_data,
    output logic                            commit_valid,
    input  logic                            commit_ready,
    output logic [4:0]                      commit_rd,
    output logic [TAG_WIDTH-1:0]            commit_tag,
    output logic [DATA_WIDTH-1:0]           commit_data,
    output logic [TAG_WIDTH:0]              count
);

    logic [ROB_SIZE-1:0]   valid, dispatched, done, rtype, rs1_rdy, rs2_rdy, sel_mask;
    logic [ROB_SIZE-1:0]   wake1, wake2, cpl;
    logic [EXEC_WIDTH-1:0] exec_id [ROB_SIZE];
    logic [DATA_WIDTH-1:0] imm [ROB_SIZE];
    logic [DATA_WIDTH-1:0] src1 [ROB_SIZE];
    logic [DATA_WIDTH-1:0] src2 [ROB_SIZE];
    logic [DATA_WIDTH-1:0] result [ROB_SIZE];
    logic [DATA_WIDTH-1:0] wake1_d [ROB_SIZE];
    logic [DATA_WIDTH-1:0] wake2_d [ROB_SIZE];
    logic [DATA_WIDTH-1:0] cpl_d [ROB_SIZE];
    logic [TAG_WIDTH-1:0]  tag1 [ROB_SIZE];
    logic [TAG_WIDTH-1:0]  tag2 [ROB_SIZE];
    logic [4:0]            rd [ROB_SIZE];

    logic [TAG_WIDTH-1:0]  cdb_t [CDB_PORTS];
    logic [DATA_WIDTH-1:0] cdb_d [CDB_PORTS];
    logic [TAG_WIDTH-1:0]  head, tail, sel_idx;
    logic                  sel_found, alloc_fire, commit_fire, flush_now;
    logic                  byp1, byp2;
    logic [DATA_WIDTH-1:0] byp1_d, byp2_d;

`ifdef ROB_FLUSH_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    assign alloc_ready  = count < (TAG_WIDTH+1)'(ROB_SIZE);
    assign alloc_tag    = tail;
    assign alloc_fire   = alloc_valid & alloc_ready & ~halt;
    assign commit_valid = valid[head] & done[head];
    assign commit_fire  = commit_valid & commit_ready & ~halt;
    assign commit_rd    = rd[head];
    assign commit_tag   = head;
    assign commit_data  = result[head];

    // First matching port wins everywhere, giving the lowest port index priority.
    always_comb begin
        byp1 = 1'b0; byp1_d = '0; byp2 = 1'b0; byp2_d = '0;
        for (int unsigned p = 0; p < CDB_PORTS; p++) begin
            cdb_t[p] = cdb_tag[p*TAG_WIDTH +: TAG_WIDTH];
            cdb_d[p] = cdb_data[p*DATA_WIDTH +: DATA_WIDTH];
            if (cdb_valid[p] && !byp1 && cdb_t[p] == rs1_tag) begin byp1 = 1'b1; byp1_d = cdb_d[p]; end
            if (cdb_valid[p] && !byp2 && cdb_t[p] == rs2_tag) begin byp2 = 1'b1; byp2_d = cdb_d[p]; end
        end
        for (int unsigned i = 0; i < ROB_SIZE; i++) begin
            wake1[i] = 1'b0; wake1_d[i] = '0;
            wake2[i] = 1'b0; wake2_d[i] = '0;
            cpl[i]   = 1'b0; cpl_d[i]   = '0;
            for (int unsigned p = 0; p < CDB_PORTS; p++) begin
                if (cdb_valid[p]) begin
                    if (!wake1[i] && cdb_t[p] == tag1[i]) begin wake1[i] = 1'b1; wake1_d[i] = cdb_d[p]; end
                    if (!wake2[i] && cdb_t[p] == tag2[i]) begin wake2[i] = 1'b1; wake2_d[i] = cdb_d[p]; end
                    if (!cpl[i] && cdb_t[p] == TAG_WIDTH'(i)) begin cpl[i] = 1'b1; cpl_d[i] = cdb_d[p]; end
                end
            end
            sel_mask[i] = valid[i] & ~dispatched[i] & rs1_rdy[i] & (rs2_rdy[i] | ~rtype[i])
                          & fu_available[exec_id[i]];
        end
    end

    // Age order is head-relative so selection stays correct across pointer wrap.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned i = 0; i < ROB_SIZE; i++) begin
            if (!sel_found && sel_mask[head + TAG_WIDTH'(i)]) begin
                sel_found = 1'b1;
                sel_idx   = head + TAG_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_now) begin
            head <= '0; tail <= '0; count <= '0;
            valid <= '0; dispatched <= '0; done <= '0; rs1_rdy <= '0; rs2_rdy <= '0;
            disp_valid <= 1'b0; disp_op1 <= '0; disp_op2 <= '0; disp_exec_id <= '0; disp_tag <= '0;
        end else if (halt) begin
            disp_valid <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                if (valid[i]) begin
                    if (!rs1_rdy[i] && wake1[i]) begin rs1_rdy[i] <= 1'b1; src1[i] <= wake1_d[i]; end
                    if (!rs2_rdy[i] && wake2[i]) begin rs2_rdy[i] <= 1'b1; src2[i] <= wake2_d[i]; end
                    if (dispatched[i] && !done[i] && cpl[i]) begin
                        done[i]   <= 1'b1;
                        result[i] <= cpl_d[i];
                    end
                end
            end
            disp_valid <= sel_found;
            if (sel_found) begin
                disp_op1             <= src1[sel_idx];
                disp_op2             <= rtype[sel_idx] ? src2[sel_idx] : imm[sel_idx];
                disp_exec_id         <= exec_id[sel_idx];
                disp_tag             <= sel_idx;
                dispatched[sel_idx]  <= 1'b1;
            end
            if (commit_fire) begin
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            if (alloc_fire) begin
                valid[tail]      <= 1'b1;
                dispatched[tail] <= 1'b0;
                done[tail]       <= 1'b0;
                rtype[tail]      <= alloc_rtype;
                exec_id[tail]    <= alloc_exec_id;
                imm[tail]        <= alloc_imm;
                rd[tail]         <= alloc_rd;
                tag1[tail]       <= rs1_tag;
                tag2[tail]       <= rs2_tag;
                rs1_rdy[tail]    <= rs1_valid | byp1;
                rs2_rdy[tail]    <= rs2_valid | byp2;
                src1[tail]       <= rs1_valid ? rs1_data : byp1_d;
                src2[tail]       <= rs2_valid ? rs2_data : byp2_d;
                tail             <= tail + 1'b1;
            end
            unique case ({alloc_fire, commit_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rob_issue_cdb.sv
// Directed bench for rob_issue_cdb: dispatch and commit scoreboards checked by a negedge monitor.
// Flush scenario compiled only with ROB_FLUSH_EN defined.
module tb_rob_issue_cdb;

    logic        clk = 1'b0, rst = 1'b1, halt = 1'b0, flush_b = 1'b0;
    logic        alloc_valid = 1'b0, alloc_ready, alloc_rtype = 1'b0;
    logic [3:0]  alloc_exec_id = '0, alloc_tag;
    logic [31:0] alloc_imm = '0;
    logic [4:0]  alloc_rd = '0;
    logic        rs1_valid = 1'b0, rs2_valid = 1'b0;
    logic [3:0]  rs1_tag = '0, rs2_tag = '0;
    logic [31:0] rs1_data = '0, rs2_data = '0;
    logic [15:0] fu_available = '1;
    logic        disp_valid;
    logic [31:0] disp_op1, disp_op2;
    logic [3:0]  disp_exec_id, disp_tag;
    logic [1:0]  cdb_valid = '0;
    logic [7:0]  cdb_tag = '0;
    logic [63:0] cdb_data = '0;
    logic        commit_valid, commit_ready = 1'b1;
    logic [4:0]  commit_rd;
    logic [3:0]  commit_tag;
    logic [31:0] commit_data;
    logic [4:0]  count;

    rob_issue_cdb #(.DATA_WIDTH(32), .ROB_SIZE(16), .TAG_WIDTH(4), .EXEC_WIDTH(4), .CDB_PORTS(2)) dut (
        .clk(clk), .rst(rst),
`ifdef ROB_FLUSH_EN
        .flush(flush_b),
`endif
        .halt(halt), .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_rtype(alloc_rtype),
        .alloc_exec_id(alloc_exec_id), .alloc_imm(alloc_imm), .alloc_rd(alloc_rd), .alloc_tag(alloc_tag),
        .rs1_valid(rs1_valid), .rs2_valid(rs2_valid), .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .fu_available(fu_available),
        .disp_valid(disp_valid), .disp_op1(disp_op1), .disp_op2(disp_op2),
        .disp_exec_id(disp_exec_id), .disp_tag(disp_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_rd(commit_rd),
        .commit_tag(commit_tag), .commit_data(commit_data), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [3:0] tag; logic [31:0] op1; logic [31:0] op2; logic [3:0] ex; } disp_t;
    typedef struct { logic [3:0] tag; logic [4:0] rd; logic [31:0] data; } cmt_t;
    disp_t disp_q[$];
    cmt_t  cmt_q[$];
    disp_t de;
    cmt_t  ce;
    int    n_vec = 0, n_miss = 0;
    logic [3:0] exp_tail = '0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (disp_valid) begin
                if (disp_q.size() == 0) check("disp_unexpected", disp_valid, 1'b0);
                else begin
                    de = disp_q.pop_front();
                    check("disp_tag", disp_tag, de.tag);
                    check("disp_op1", disp_op1, de.op1);
                    check("disp_op2", disp_op2, de.op2);
                    check("disp_exec_id", disp_exec_id, de.ex);
                end
            end
            if (commit_valid && commit_ready && !halt && !flush_b) begin
                if (cmt_q.size() == 0) check("commit_unexpected", commit_valid, 1'b0);
                else begin
                    ce = cmt_q.pop_front();
                    check("commit_tag", commit_tag, ce.tag);
                    check("commit_rd", commit_rd, ce.rd);
                    check("commit_data", commit_data, ce.data);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_disp(input logic [3:0] t, input logic [31:0] a, input logic [31:0] b, input logic [3:0] ex);
        disp_q.push_back('{tag: t, op1: a, op2: b, ex: ex});
    endtask

    task automatic push_cmt(input logic [3:0] t, input logic [4:0] r, input logic [31:0] d);
        cmt_q.push_back('{tag: t, rd: r, data: d});
    endtask

    task automatic do_reset();
        rst = 1'b1; alloc_valid = 1'b0; cdb_valid = '0; halt = 1'b0; flush_b = 1'b0;
        fu_available = '1; commit_ready = 1'b1;
        step(2);
        rst = 1'b0;
        exp_tail = '0;
    endtask

    task automatic drive_alloc(input logic rt, input logic [3:0] ex, input logic [31:0] im, input logic [4:0] r,
                               input logic v1, input logic [3:0] t1, input logic [31:0] d1,
                               input logic v2, input logic [3:0] t2, input logic [31:0] d2);
        alloc_valid = 1'b1; alloc_rtype = rt; alloc_exec_id = ex; alloc_imm = im; alloc_rd = r;
        rs1_valid = v1; rs1_tag = t1; rs1_data = d1; rs2_valid = v2; rs2_tag = t2; rs2_data = d2;
    endtask

    task automatic finish_alloc();
        int n = 0;
        while (!alloc_ready && n < 50) begin step(1); n++; end
        check("alloc_ready_wait", alloc_ready, 1'b1);
        check("alloc_tag", alloc_tag, exp_tail);
        step(1);
        alloc_valid = 1'b0;
        exp_tail++;
    endtask

    task automatic alloc_rr(input logic [3:0] ex, input logic [4:0] r, input logic [31:0] a, input logic [31:0] b);
        drive_alloc(1'b1, ex, 32'h0, r, 1'b1, 4'h0, a, 1'b1, 4'h0, b);
        finish_alloc();
    endtask

    task automatic cdb(input logic v0, input logic [3:0] t0, input logic [31:0] d0,
                       input logic v1, input logic [3:0] t1, input logic [31:0] d1);
        cdb_valid = {v1, v0}; cdb_tag = {t1, t0}; cdb_data = {d1, d0};
        step(1);
        cdb_valid = '0;
    endtask

    task automatic wait_disp_drain();
        int n = 0;
        while (disp_q.size() != 0 && n < 60) begin step(1); n++; end
        check("disp_drain", disp_q.size(), 0);
    endtask

    task automatic wait_empty();
        int n = 0;
        while ((count != 0 || cmt_q.size() != 0) && n < 100) begin step(1); n++; end
        check("empty_count", count, 0);
        check("commit_drain", cmt_q.size(), 0);
    endtask

    initial begin
        // 1: reset state, three ready ADDs dispatched in order
        do_reset();
        check("rst_count", count, 0);
        check("rst_alloc_ready", alloc_ready, 1'b1);
        check("rst_commit_valid", commit_valid, 1'b0);
        check("rst_disp_valid", disp_valid, 1'b0);
        check("rst_alloc_tag", alloc_tag, 0);
        for (int unsigned i = 0; i < 3; i++) begin
            alloc_rr(4'(i + 1), 5'(i + 1), 32'(10 + i), 32'(20 + i));
            push_disp(4'(i), 32'(10 + i), 32'(20 + i), 4'(i + 1));
        end
        wait_disp_drain();
        for (int unsigned i = 0; i < 3; i++) begin
            push_cmt(4'(i), 5'(i + 1), 32'(100 + i));
            cdb(1'b1, 4'(i), 32'(100 + i), 1'b0, 4'h0, 32'h0);
        end
        wait_empty();

        // 2: wakeup through CDB port1, then oldest-first skip past a busy FU
        do_reset();
        fu_available[5] = 1'b0;
        drive_alloc(1'b0, 4'd5, 32'd7, 5'd10, 1'b1, 4'h0, 32'd3, 1'b1, 4'h0, 32'h0);
        finish_alloc();
        drive_alloc(1'b0, 4'd2, 32'd9, 5'd11, 1'b0, 4'd0, 32'h0, 1'b1, 4'h0, 32'h0);
        finish_alloc();
        step(3);
        fu_available[5] = 1'b1;
        push_disp(4'd0, 32'd3, 32'd7, 4'd5);
        wait_disp_drain();
        push_disp(4'd1, 32'hAB, 32'd9, 4'd2);
        push_cmt(4'd0, 5'd10, 32'hAB);
        cdb(1'b0, 4'h0, 32'h0, 1'b1, 4'd0, 32'hAB);
        wait_disp_drain();
        push_cmt(4'd1, 5'd11, 32'h55);
        cdb(1'b1, 4'd1, 32'h55, 1'b0, 4'h0, 32'h0);
        wait_empty();
        fu_available[6] = 1'b0;
        alloc_rr(4'd6, 5'd12, 32'h61, 32'h62);
        alloc_rr(4'd1, 5'd13, 32'h71, 32'h72);
        push_disp(4'd3, 32'h71, 32'h72, 4'd1);
        wait_disp_drain();
        fu_available[6] = 1'b1;
        push_disp(4'd2, 32'h61, 32'h62, 4'd6);
        wait_disp_drain();
        cdb(1'b1, 4'd3, 32'h333, 1'b0, 4'h0, 32'h0);
        step(1);
        check("young_done_no_commit", commit_valid, 1'b0);
        push_cmt(4'd2, 5'd12, 32'h222);
        push_cmt(4'd3, 5'd13, 32'h333);
        cdb(1'b1, 4'd2, 32'h222, 1'b0, 4'h0, 32'h0);
        wait_empty();

        // 3: fill, commit head while alloc waits, tail wraps to 0
        do_reset();
        for (int unsigned i = 0; i < 16; i++) begin
            drive_alloc(1'b0, 4'(i), 32'(i * 3), 5'(i), 1'b1, 4'h0, 32'(256 + i), 1'b0, 4'h0, 32'h0);
            finish_alloc();
            push_disp(4'(i), 32'(256 + i), 32'(i * 3), 4'(i));
        end
        check("full_alloc_ready", alloc_ready, 1'b0);
        check("full_count", count, 16);
        wait_disp_drain();
        drive_alloc(1'b0, 4'd2, 32'h5A, 5'd7, 1'b1, 4'h0, 32'h33, 1'b0, 4'h0, 32'h0);
        push_cmt(4'd0, 5'd0, 32'hC0);
        cdb(1'b1, 4'd0, 32'hC0, 1'b0, 4'h0, 32'h0);
        finish_alloc();
        check("wrap_count", count, 16);
        push_disp(4'd0, 32'h33, 32'h5A, 4'd2);
        wait_disp_drain();
        for (int unsigned i = 1; i < 16; i++) begin
            push_cmt(4'(i), 5'(i), 32'(4096 + i));
            cdb(1'b1, 4'(i), 32'(4096 + i), 1'b0, 4'h0, 32'h0);
        end
        push_cmt(4'd0, 5'd7, 32'hD0);
        cdb(1'b1, 4'd0, 32'hD0, 1'b0, 4'h0, 32'h0);
        wait_empty();

        // 4: out-of-order completion, in-order commit; dual-port hit keeps port0 data
        do_reset();
        for (int unsigned i = 0; i < 3; i++) begin
            alloc_rr(4'd1, 5'(i + 1), 32'(i), 32'(i + 5));
            push_disp(4'(i), 32'(i), 32'(i + 5), 4'd1);
        end
        wait_disp_drain();
        cdb(1'b1, 4'd2, 32'h222, 1'b0, 4'h0, 32'h0);
        step(2);
        check("ooo_commit_hold2", commit_valid, 1'b0);
        cdb(1'b1, 4'd1, 32'h111, 1'b1, 4'd1, 32'h999);
        check("ooo_commit_hold1", commit_valid, 1'b0);
        push_cmt(4'd0, 5'd1, 32'h100);
        push_cmt(4'd1, 5'd2, 32'h111);
        push_cmt(4'd2, 5'd3, 32'h222);
        cdb(1'b1, 4'd0, 32'h100, 1'b0, 4'h0, 32'h0);
        wait_empty();

        // 5: alloc-cycle bypass on rs2, both ports match, port0 wins
        do_reset();
        drive_alloc(1'b1, 4'd3, 32'h0, 5'd4, 1'b1, 4'h0, 32'h11, 1'b0, 4'd5, 32'h0);
        cdb_valid = 2'b11; cdb_tag = {4'd5, 4'd5}; cdb_data = {32'h99, 32'h77};
        finish_alloc();
        cdb_valid = '0;
        push_disp(4'd0, 32'h11, 32'h77, 4'd3);
        wait_disp_drain();
        check("ignored_tag_count", count, 1);
        push_cmt(4'd0, 5'd4, 32'hE0);
        cdb(1'b1, 4'd0, 32'hE0, 1'b0, 4'h0, 32'h0);
        wait_empty();

        // halt freezes alloc and suppresses a pending dispatch
        do_reset();
        drive_alloc(1'b1, 4'd8, 32'h0, 5'd9, 1'b1, 4'h0, 32'hA1, 1'b1, 4'h0, 32'hA2);
        halt = 1'b1;
        step(3);
        check("halt_count", count, 0);
        halt = 1'b0;
        finish_alloc();
        halt = 1'b1;
        step(2);
        check("halt_disp_valid", disp_valid, 1'b0);
        check("halt_disp_pending", disp_q.size(), 0);
        halt = 1'b0;
        push_disp(4'd0, 32'hA1, 32'hA2, 4'd8);
        wait_disp_drain();
        push_cmt(4'd0, 5'd9, 32'hF0);
        cdb(1'b1, 4'd0, 32'hF0, 1'b0, 4'h0, 32'h0);
        wait_empty();

        // rst discards a ready entry before its dispatch registers
        alloc_rr(4'd1, 5'd2, 32'h1, 32'h2);
        do_reset();
        step(3);
        check("rst_mid_count", count, 0);
        check("rst_mid_disp", disp_valid, 1'b0);

`ifdef ROB_FLUSH_EN
        // 6: flush with five live entries
        do_reset();
        for (int unsigned i = 0; i < 5; i++) begin
            drive_alloc(1'b0, 4'd1, 32'(i), 5'(i), 1'b0, 4'd9, 32'h0, 1'b0, 4'h0, 32'h0);
            finish_alloc();
        end
        check("pre_flush_count", count, 5);
        flush_b = 1'b1;
        step(1);
        flush_b = 1'b0;
        exp_tail = '0;
        check("flush_count", count, 0);
        check("flush_commit_valid", commit_valid, 1'b0);
        check("flush_alloc_tag", alloc_tag, 0);
        alloc_rr(4'd4, 5'd6, 32'h42, 32'h43);
        push_disp(4'd0, 32'h42, 32'h43, 4'd4);
        wait_disp_drain();
        push_cmt(4'd0, 5'd6, 32'h44);
        cdb(1'b1, 4'd0, 32'h44, 1'b0, 4'h0, 32'h0);
        wait_empty();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
